// File: rtl/lsu_axi_master.sv
// AXI4-Lite initiator for a single-outstanding core load/store port; read response lands 3 cycles after accept at best.
// Core is held off (req_ready_o low) from accept until the response pulse; optional per-handshake timeout aborts to an error response.
module lsu_axi_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wait_st;
  logic                to_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_hit    = 1'b0;
    wait_st   = (state_q inside {S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP});
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        addr_d    = req_addr_i;
        wdata_d   = req_wdata_i;
        wstrb_d   = req_wstrb_i;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        state_d   = req_wen_i ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: if (arready_i) state_d = S_RD_DATA;
      S_RD_DATA: if (rvalid_i) begin
        rdata_d = rdata_i;
        err_d   = (rresp_i != 2'b00);
        state_d = S_RESP;
      end
      S_WR_REQ: begin
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: if (bvalid_i) begin
        rdata_d = '0;
        err_d   = (bresp_i != 2'b00);
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A handshake completing on the deadline cycle wins over the abort.
    if (TO_EN && wait_st && (state_d == state_q) && (cnt_q == TO_LAST)) begin
      to_hit  = 1'b1;
      rdata_d = '0;
      err_d   = 1'b1;
      state_d = S_RESP;
    end
    if (state_d != state_q) cnt_d = '0;
    else if (wait_st)       cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = '0;
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    arvalid_o    = (state_q == S_RD_ADDR);
    rready_o     = (state_q == S_RD_DATA);
    awvalid_o    = (state_q == S_WR_REQ) && !aw_done_q;
    wvalid_o     = (state_q == S_WR_REQ) && !w_done_q;
    bready_o     = (state_q == S_WR_RESP);
    resp_valid_o = (state_q == S_RESP);
    resp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
    resp_err_o   = (state_q == S_RESP) && err_q;
    araddr_o     = addr_q;
    awaddr_o     = addr_q;
    wdata_o      = wdata_q;
    wstrb_o      = wstrb_q;
  end

`ifndef __SYNTHESIS__
  a_ar_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (arvalid_o && !arready_i && !to_hit) |=> (arvalid_o && $stable(araddr_o)));
  a_aw_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (awvalid_o && !awready_i && !to_hit) |=> (awvalid_o && $stable(awaddr_o)));
  a_w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (wvalid_o && !wready_i && !to_hit) |=> (wvalid_o && $stable(wdata_o) && $stable(wstrb_o)));
`endif
endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: transaction-level model checked every cycle plus directed literal checks.
module tb_lsu_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  int          n_chk = 0;
  int          n_fail = 0;

  // instance A (no timeout)
  logic        req_valid, req_ready, req_wen, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  // instance B (TIMEOUT=4)
  logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wstrb;
  logic [31:0] b_araddr, b_rdata, b_awaddr, b_wdata;
  logic        b_arvalid, b_arready, b_rvalid, b_rready, b_awvalid, b_awready, b_wvalid, b_wready;
  logic        b_bvalid, b_bready;
  logic [1:0]  b_rresp, b_bresp;
  logic [3:0]  b_wstrb;

  always #5 clk = ~clk;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wen_i(b_req_wen),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_wstrb_i(b_req_wstrb),
    .resp_valid_o(b_resp_valid), .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
    .araddr_o(b_araddr), .arvalid_o(b_arvalid), .arready_i(b_arready),
    .rdata_i(b_rdata), .rresp_i(b_rresp), .rvalid_i(b_rvalid), .rready_o(b_rready),
    .awaddr_o(b_awaddr), .awvalid_o(b_awvalid), .awready_i(b_awready),
    .wdata_o(b_wdata), .wstrb_o(b_wstrb), .wvalid_o(b_wvalid), .wready_i(b_wready),
    .bresp_i(b_bresp), .bvalid_i(b_bvalid), .bready_o(b_bready)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model for instance A: which handshakes of the current transfer have completed.
  logic        m_live = 1'b0;
  logic        m_busy, m_wen, m_ar, m_r, m_aw, m_w, m_b, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  always @(posedge clk) begin
    logic bphase;
    m_live = 1'b1;
    if (rst) begin
      m_busy = 1'b0; m_ar = 1'b0; m_r = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_b = 1'b0;
      m_wen = 1'b0; m_err = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1; m_wen = req_wen; m_addr = req_addr; m_wdata = req_wdata; m_wstrb = req_wstrb;
        m_ar = 1'b0; m_r = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_b = 1'b0;
      end
    end else if (m_r || m_b) begin
      m_busy = 1'b0;
    end else if (!m_wen) begin
      if (!m_ar) m_ar = arready;
      else if (rvalid) begin
        m_r = 1'b1; m_rdata = rdata; m_err = (rresp != 2'b00);
      end
    end else begin
      bphase = m_aw && m_w;
      if (bphase) begin
        if (bvalid) begin
          m_b = 1'b1; m_rdata = '0; m_err = (bresp != 2'b00);
        end
      end else begin
        if (awready) m_aw = 1'b1;
        if (wready)  m_w  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic e_ar, e_r, e_aw, e_w, e_b, e_resp;
      e_ar   = m_busy && !m_wen && !m_ar;
      e_r    = m_busy && !m_wen && m_ar && !m_r;
      e_aw   = m_busy && m_wen && !m_aw;
      e_w    = m_busy && m_wen && !m_w;
      e_b    = m_busy && m_wen && m_aw && m_w && !m_b;
      e_resp = m_busy && (m_r || m_b);
      chk1("m_req_ready", req_ready, !m_busy);
      chk1("m_arvalid", arvalid, e_ar);
      chk1("m_rready", rready, e_r);
      chk1("m_awvalid", awvalid, e_aw);
      chk1("m_wvalid", wvalid, e_w);
      chk1("m_bready", bready, e_b);
      chk1("m_resp_valid", resp_valid, e_resp);
      if (e_ar) chk32("m_araddr", araddr, m_addr);
      if (e_aw) chk32("m_awaddr", awaddr, m_addr);
      if (e_w) begin
        chk32("m_wdata", wdata, m_wdata);
        chk32("m_wstrb", 32'(wstrb), 32'(m_wstrb));
      end
      if (e_resp) begin
        chk32("m_resp_rdata", resp_rdata, m_rdata);
        chk1("m_resp_err", resp_err, m_err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 0; rdata = '0; rresp = '0; rvalid = 0; awready = 0; wready = 0; bresp = '0; bvalid = 0;
    b_req_valid = 0; b_req_wen = 0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_arready = 0; b_rdata = '0; b_rresp = '0; b_rvalid = 0; b_awready = 0; b_wready = 0;
    b_bresp = '0; b_bvalid = 0;
    repeat (2) tick();
    rst = 1'b0;

    // reset state
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_araddr", araddr, 32'h0);
    chk1("rst_b_req_ready", b_req_ready, 1'b1);

    // read, arready immediate, rvalid one cycle late
    req_valid = 1; req_wen = 0; req_addr = 32'h0200_0000; arready = 1;
    tick();
    req_valid = 0;
    chk1("rd_arvalid", arvalid, 1'b1);
    chk32("rd_araddr", araddr, 32'h0200_0000);
    chk1("rd_req_ready", req_ready, 1'b0);
    tick();
    arready = 0;
    chk1("rd_rready", rready, 1'b1);
    tick();
    rvalid = 1; rdata = 32'h0000_1234; rresp = 2'b00;
    tick();
    rvalid = 0;
    chk1("rd_resp_valid", resp_valid, 1'b1);
    chk32("rd_resp_rdata", resp_rdata, 32'h0000_1234);
    chk1("rd_resp_err", resp_err, 1'b0);
    tick();
    chk1("rd_pulse_end", resp_valid, 1'b0);
    chk1("rd_idle_ready", req_ready, 1'b1);

    // write, awready first, wready two cycles later
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0010; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    tick();
    req_valid = 0; awready = 1;
    chk1("wr_awvalid1", awvalid, 1'b1);
    chk1("wr_wvalid1", wvalid, 1'b1);
    tick();
    awready = 0;
    chk1("wr_awvalid2", awvalid, 1'b0);
    chk1("wr_wvalid2", wvalid, 1'b1);
    tick();
    wready = 1;
    chk1("wr_wvalid3", wvalid, 1'b1);
    chk32("wr_wdata3", wdata, 32'hDEAD_BEEF);
    tick();
    wready = 0;
    chk1("wr_wvalid4", wvalid, 1'b0);
    chk1("wr_bready", bready, 1'b1);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk1("wr_resp_valid", resp_valid, 1'b1);
    chk1("wr_resp_err", resp_err, 1'b0);
    chk32("wr_resp_rdata", resp_rdata, 32'h0);
    tick();

    // write, both handshakes same cycle, SLVERR response
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678; req_wstrb = 4'h3;
    tick();
    req_valid = 0; awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    chk1("wr2_bready", bready, 1'b1);
    chk1("wr2_awvalid", awvalid, 1'b0);
    chk1("wr2_wvalid", wvalid, 1'b0);
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 2'b00;
    chk1("wr2_resp_err", resp_err, 1'b1);
    chk32("wr2_resp_rdata", resp_rdata, 32'h0);
    tick();

    // read with arready stalled 5 cycles; core inputs and stray bvalid ignored
    req_valid = 1; req_wen = 0; req_addr = 32'h1000_0004;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("stall_arvalid", arvalid, 1'b1);
      chk32("stall_araddr", araddr, 32'h1000_0004);
      chk1("stall_req_ready", req_ready, 1'b0);
      chk1("stall_bready", bready, 1'b0);
      req_valid = 1; req_wen = 1; req_addr = 32'hAAAA_0000 + 32'(i); bvalid = 1;
      tick();
    end
    req_valid = 0; req_wen = 0; bvalid = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b11;
    tick();
    rvalid = 0; rresp = 2'b00;
    chk32("stall_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    chk1("stall_resp_err", resp_err, 1'b1);
    tick();

    // reset while waiting for read data, then a fresh read
    req_valid = 1; req_wen = 0; req_addr = 32'h0200_0008; arready = 1;
    tick();
    req_valid = 0;
    tick();
    arready = 0;
    chk1("rstm_rready_before", rready, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk1("rstm_rready", rready, 1'b0);
    chk1("rstm_arvalid", arvalid, 1'b0);
    chk1("rstm_req_ready", req_ready, 1'b1);
    chk1("rstm_resp_valid", resp_valid, 1'b0);
    req_valid = 1; req_addr = 32'h0200_0000; arready = 1; rvalid = 1; rdata = 32'h0000_55AA;
    tick();
    req_valid = 0;
    tick();
    arready = 0;
    tick();
    rvalid = 0;
    chk1("rstm_fresh_valid", resp_valid, 1'b1);
    chk32("rstm_fresh_rdata", resp_rdata, 32'h0000_55AA);
    tick();

    // timeout instance: arready never comes, request held for back-to-back
    b_req_valid = 1; b_req_wen = 0; b_req_addr = 32'h0200_0100;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk1("to_arvalid_wait", b_arvalid, 1'b1);
      chk1("to_resp_wait", b_resp_valid, 1'b0);
      tick();
    end
    chk1("to_resp_valid", b_resp_valid, 1'b1);
    chk1("to_resp_err", b_resp_err, 1'b1);
    chk32("to_resp_rdata", b_resp_rdata, 32'h0);
    chk1("to_arvalid_drop", b_arvalid, 1'b0);
    chk1("to_req_ready_resp", b_req_ready, 1'b0);
    tick();
    chk1("to_idle_ready", b_req_ready, 1'b1);
    chk1("to_idle_arvalid", b_arvalid, 1'b0);
    chk1("to_idle_resp", b_resp_valid, 1'b0);
    b_arready = 1;
    tick();
    chk1("to_b2b_arvalid", b_arvalid, 1'b1);
    chk32("to_b2b_araddr", b_araddr, 32'h0200_0100);
    chk1("to_b2b_awvalid", b_awvalid, 1'b0);
    b_req_valid = 0; b_rvalid = 1; b_rdata = 32'h0000_0077;
    tick();
    b_arready = 0;
    chk1("to_b2b_rready", b_rready, 1'b1);
    tick();
    b_rvalid = 0;
    chk1("to_b2b_resp_valid", b_resp_valid, 1'b1);
    chk32("to_b2b_rdata", b_resp_rdata, 32'h0000_0077);
    chk1("to_b2b_err", b_resp_err, 1'b0);
    chk1("to_b2b_bready", b_bready, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
